// File: rtl/chip8_keypad_if.sv
// Keypad <-> CPU bundle: matrix drive/sense, debounced key map, key query and Fx0A wait handshake.
// The CPU side uses the master modport; the keypad scanner uses the slave modport.
interface chip8_keypad_if;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [15:0] keys;
    logic [3:0]  key_query;
    logic        key_pressed;
    logic        wait_req;
    logic        wait_ack;
    logic [3:0]  wait_key;

    modport master (
        input  col_out, keys, key_pressed, wait_ack, wait_key,
        output row_in, key_query, wait_req
    );

    modport slave (
        output col_out, keys, key_pressed, wait_ack, wait_key,
        input  row_in, key_query, wait_req
    );
endinterface

// File: rtl/chip8_keypad.sv
// 4x4 matrix keypad scanner with per-key debounce, single-key query and Fx0A wait handshake.
// Define KEYPAD_RELEASE_WAIT_EN to make Fx0A capture key releases instead of presses.
module chip8_keypad #(
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    chip8_keypad_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_LAST   = 4'(DEBOUNCE - 1);
    // Hex code of (row, col), nibble index {row, col}.
    localparam logic [63:0] HEX_MAP   = 64'hFB0A_E987_D654_C321;

    logic [15:0] slot_q, slot_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  row_meta_q, row_meta_d;
    logic [3:0]  row_sync_q, row_sync_d;
    logic [15:0] keys_q, keys_d;
    logic [3:0]  cnt_q [16];
    logic [3:0]  cnt_d [16];
    state_e      state_q, state_d;
    logic        wait_ack_q, wait_ack_d;
    logic [3:0]  wait_key_q, wait_key_d;

    logic        sample_en;
    logic [15:0] cap_vec;
    logic [3:0]  cap_hex;
    logic [5:0]  map_idx;
    logic [3:0]  h;
    logic        smp;

    assign sample_en = (slot_q == SLOT_LAST);

    // Scan counters, synchroniser and per-key debounce.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        slot_d     = sample_en ? 16'd0 : slot_q + 16'd1;
        col_d      = sample_en ? col_q + 2'd1 : col_q;
        row_meta_d = bus.row_in;
        row_sync_d = row_meta_q;
        keys_d     = keys_q;
        cnt_d      = cnt_q;
        cap_vec    = '0;
        map_idx    = '0;
        h          = '0;
        smp        = 1'b0;
        if (sample_en) begin
            for (int r = 0; r < 4; r++) begin
                map_idx = {2'(r), col_q, 2'b00};
                h       = HEX_MAP[map_idx +: 4];
                smp     = ~row_sync_q[r];
                if (smp == keys_q[h]) begin
                    cnt_d[h] = 4'd0;
                end else if (cnt_q[h] == DB_LAST) begin
                    keys_d[h] = smp;
                    cnt_d[h]  = 4'd0;
`ifdef KEYPAD_RELEASE_WAIT_EN
                    cap_vec[h] = ~smp;
`else
                    cap_vec[h] = smp;
`endif
                end else begin
                    cnt_d[h] = cnt_q[h] + 4'd1;
                end
            end
        end
    end

    // Lowest hex code wins when several keys flip in the same sample.
    always_comb begin
        cap_hex = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cap_vec[i]) cap_hex = 4'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_ack_d = 1'b0;
        wait_key_d = wait_key_q;
        case (state_q)
            IDLE:  if (bus.wait_req) state_d = ARMED;
            ARMED: begin
                if (!bus.wait_req) begin
                    state_d = IDLE;
                end else if (|cap_vec) begin
                    state_d    = DONE;
                    wait_ack_d = 1'b1;
                    wait_key_d = cap_hex;
                end
            end
            DONE:  if (!bus.wait_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            col_q      <= '0;
            row_meta_q <= '0;
            row_sync_q <= '0;
            keys_q     <= '0;
            // NOTE: the debounce counter array is reset because a stale count would skew the first flip.
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
            state_q    <= IDLE;
            wait_ack_q <= 1'b0;
            wait_key_q <= '0;
        end else begin
            slot_q     <= slot_d;
            col_q      <= col_d;
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            keys_q     <= keys_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            wait_ack_q <= wait_ack_d;
            wait_key_q <= wait_key_d;
        end
    end

    assign bus.col_out     = ~(4'b0001 << col_q);
    assign bus.keys        = keys_q;
    assign bus.key_pressed = keys_q[bus.key_query];
    assign bus.wait_ack    = wait_ack_q;
    assign bus.wait_key    = wait_key_q;

endmodule

// File: tb/tb_chip8_keypad.sv
// Self-checking bench for chip8_keypad: a physical keypad model drives row_in and a
// scan-level reference model predicts col_out, keys, key_pressed and the Fx0A handshake.
module tb_chip8_keypad;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
`ifdef KEYPAD_RELEASE_WAIT_EN
    localparam bit REL_MODE = 1'b1;
`else
    localparam bit REL_MODE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    chip8_keypad_if bus ();

    chip8_keypad #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Hex code at row*4+col of the keypad face.
    int rc2hex [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

    logic [15:0] phys;   // physically held keys

    always_comb begin
        bus.row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.col_out[c] && phys[rc2hex[r*4+c]]) bus.row_in[r] = 1'b0;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int n_ack  = 0;

    // Reference model state
    logic [15:0] m_keys;
    int          m_streak [16];
    int          m_cyc;
    int          m_state;      // 0 idle, 1 waiting for a key, 2 answered
    logic        m_ack;
    logic [3:0]  m_key;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_keys  = '0;
        for (int i = 0; i < 16; i++) m_streak[i] = 0;
        m_cyc   = 0;
        m_state = 0;
        m_ack   = 1'b0;
        m_key   = '0;
    endtask

    // One clock edge of the reference: a sample every SCAN_DIV cycles of the current column.
    task automatic model_edge();
        int  c, h, hx;
        bit  hit;
        hit = 1'b0;
        hx  = 0;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
            c = (m_cyc / SCAN_DIV) % 4;
            for (int r = 0; r < 4; r++) begin
                h = rc2hex[r*4+c];
                if (phys[h] != m_keys[h]) begin
                    m_streak[h]++;
                    if (m_streak[h] == DEBOUNCE) begin
                        m_keys[h]   = phys[h];
                        m_streak[h] = 0;
                        if (phys[h] != REL_MODE && (!hit || h < hx)) begin
                            hit = 1'b1;
                            hx  = h;
                        end
                    end
                end else begin
                    m_streak[h] = 0;
                end
            end
        end
        m_ack = 1'b0;
        case (m_state)
            0: if (bus.wait_req) m_state = 1;
            1: begin
                if (!bus.wait_req) m_state = 0;
                else if (hit) begin
                    m_state = 2;
                    m_ack   = 1'b1;
                    m_key   = 4'(hx);
                end
            end
            default: if (!bus.wait_req) m_state = 0;
        endcase
        m_cyc++;
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        @(posedge clk);
        model_edge();
        #1;
        bus.key_query = 4'($urandom_range(0, 15));
        #1;
        exp_col = 4'hF ^ (4'b0001 << ((m_cyc / SCAN_DIV) % 4));
        if (bus.wait_ack) n_ack++;
        check("col_out", 32'(bus.col_out), 32'(exp_col));
        check("keys", 32'(bus.keys), 32'(m_keys));
        check("key_pressed", 32'(bus.key_pressed), 32'(m_keys[bus.key_query]));
        check("wait_ack", 32'(bus.wait_ack), 32'(m_ack));
        check("wait_key", 32'(bus.wait_key), 32'(m_key));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next cycle is slot 0 of column col (key changes are safe there).
    task automatic to_boundary(input int col);
        for (int i = 0; i < 4 * SCAN_DIV + 1; i++) begin
            if (m_cyc % SCAN_DIV == 0 && (m_cyc / SCAN_DIV) % 4 == col) break;
            tick();
        end
    endtask

    initial begin
        int a0;
        phys          = '0;
        bus.wait_req  = 1'b0;
        bus.key_query = 4'd0;
        model_reset();

        // Reset values
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_col_out", 32'(bus.col_out), 32'hE);
        check("rst_keys", 32'(bus.keys), 32'h0);
        check("rst_wait_ack", 32'(bus.wait_ack), 32'h0);
        check("rst_wait_key", 32'(bus.wait_key), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running scan, no keys
        run(32);

        // Key 6 (row1, col2): press, query, release
        to_boundary(2);
        phys[6] = 1'b1;
        run(64);
        check("key6_held", 32'(bus.keys), 32'h0040);
        bus.key_query = 4'd6;
        #1 check("query6", 32'(bus.key_pressed), 32'h1);
        bus.key_query = 4'd5;
        #1 check("query5", 32'(bus.key_pressed), 32'h0);
        to_boundary(2);
        phys[6] = 1'b0;
        run(64);
        check("key6_released", 32'(bus.keys), 32'h0);

        // Single-sample glitches on key A separated by one agreeing sample
        to_boundary(0);
        phys[10] = 1'b1;
        run(4);
        phys[10] = 1'b0;
        run(28);
        phys[10] = 1'b1;
        run(4);
        phys[10] = 1'b0;
        run(16);
        check("glitch_a", 32'(bus.keys), 32'h0);

        // Fx0A with key 0 (row3, col1): one ack per request
        bus.wait_req = 1'b1;
        tick();
        a0 = n_ack;
        to_boundary(1);
        phys[0] = 1'b1;
        run(64);
`ifndef KEYPAD_RELEASE_WAIT_EN
        check("ack_once", 32'(n_ack - a0), 32'd1);
        check("wait_key0", 32'(bus.wait_key), 32'h0);
`endif
        phys[0] = 1'b0;
        run(32);
        bus.wait_req = 1'b0;
        run(2);
        bus.wait_req = 1'b1;
        run(2);
        to_boundary(1);
        phys[0] = 1'b1;
        run(48);
`ifndef KEYPAD_RELEASE_WAIT_EN
        check("ack_second", 32'(n_ack - a0), 32'd2);
`endif
        phys[0] = 1'b0;
        run(32);
        bus.wait_req = 1'b0;
        run(2);

        // Key 5 held before arming, then keys 1 and 4 together
        to_boundary(1);
        phys[5] = 1'b1;
        run(48);
        bus.wait_req = 1'b1;
        run(2);
        a0 = n_ack;
        to_boundary(0);
        phys[1] = 1'b1;
        phys[4] = 1'b1;
        run(48);
`ifndef KEYPAD_RELEASE_WAIT_EN
        check("tie_ack", 32'(n_ack - a0), 32'd1);
        check("tie_key", 32'(bus.wait_key), 32'h1);
`endif

        // Reset while armed with a debounce in progress
        bus.wait_req = 1'b0;
        run(2);
        bus.wait_req = 1'b1;
        run(2);
        to_boundary(2);
        phys[9] = 1'b1;
        run(4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wait_ack", 32'(bus.wait_ack), 32'h0);
        check("midrst_keys", 32'(bus.keys), 32'h0);
        check("midrst_col_out", 32'(bus.col_out), 32'hE);
        phys         = '0;
        bus.wait_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        // Key F held at arming, then released
        to_boundary(3);
        phys[15] = 1'b1;
        run(48);
        bus.wait_req = 1'b1;
        tick();
        a0 = n_ack;
        to_boundary(3);
        phys[15] = 1'b0;
        run(48);
`ifdef KEYPAD_RELEASE_WAIT_EN
        check("release_ack", 32'(n_ack - a0), 32'd1);
        check("release_key", 32'(bus.wait_key), 32'hF);
`else
        check("release_no_ack", 32'(n_ack - a0), 32'd0);
`endif
        bus.wait_req = 1'b0;
        run(2);

        // Randomized key activity and request toggling
        to_boundary(0);
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) == 0) phys = phys ^ (16'h0001 << $urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) bus.wait_req = ~bus.wait_req;
            run(SCAN_DIV);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_keypad.md
Name: chip8_keypad

Overview:
- Scans a 4x4 active-low matrix keypad and debounces every key.
- Presents a 16-bit debounced key map plus a combinational single-key query port, used by the CPU for SKP/SKNP.
- Provides a request/ack handshake for LD Vx, K (Fx0A): the CPU asserts a request and receives the hex code of the next key press.
- Sits directly upstream of the cpu block and runs in the same clk domain.

Parameters:
- SCAN_DIV, 1024: clk cycles each column is driven. Legal range 4..65535.
- DEBOUNCE, 3: consecutive disagreeing samples of one key required to flip its state. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- col_out  out  4  column drive, active-low, exactly one bit low at a time.
- row_in  in  4  row sense, active-low, externally pulled up, asynchronous.
- keys  out  16  debounced state; keys[h]=1 means hex key h is held.
- key_query  in  4  hex key index to test.
- key_pressed  out  1  combinational: keys[key_query].
- wait_req  in  1  level; CPU is executing Fx0A.
- wait_ack  out  1  one-cycle pulse: key captured.
- wait_key  out  4  captured hex code; valid with wait_ack and held until the next capture.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: col_out=4'b1110, keys=0, wait_ack=0, wait_key=0. All debounce counters, the synchroniser, the slot counter and the column index clear to 0. The handshake FSM goes to IDLE.
- Key map (row r, column c -> hex):
  - r0: 1 2 3 C
  - r1: 4 5 6 D
  - r2: 7 8 9 E
  - r3: A 0 B F
- Scan:
  - slot counter runs 0..SCAN_DIV-1; column index c runs 0..3.
  - col_out = ~(1<<c).
  - When the slot counter wraps, c increments; c wraps 3->0.
  - Full scan period = 4*SCAN_DIV cycles.
- Sampling:
  - row_in passes through a 2-flop synchroniser.
  - The synchronised row is sampled on slot count SCAN_DIV-1, i.e. at least 2 cycles after the column changed, so the synchroniser has settled.
  - A row bit of 0 means the key at (r, c) is pressed.
  - Only the 4 keys of the current column are updated per sample.
- Debounce, per key:
  - Counter width 4 bits.
  - Sample equals keys[h]: counter <= 0.
  - Sample differs and counter == DEBOUNCE-1: keys[h] toggles and counter <= 0.
  - Otherwise: counter increments.
  - Resulting latency: the key state changes on the DEBOUNCE-th consecutive disagreeing sample of that key.
- Handshake FSM, states IDLE, ARMED, DONE:
  - IDLE: wait_req=1 -> ARMED.
  - ARMED: wait_req=0 -> IDLE with no ack. A debounced rising edge (keys[h] 0->1) of any key -> DONE. In the same cycle, wait_key <= h and wait_ack pulses high for exactly 1 cycle.
  - DONE: stays until wait_req=0, then -> IDLE. This gives no second ack within one request.
  - Keys already held when ARMED is entered do not count until released and pressed again.
- Simultaneous rising edges in one sample (same column): capture the lowest hex value.
- key_pressed is purely combinational from keys and key_query.
- Reset mid-scan or mid-handshake: all state returns to its reset values immediately, with no ack. After rst_n rises, scanning restarts at column 0, slot 0.

Optional Feature:
- Macro: KEYPAD_RELEASE_WAIT_EN.
- Defined:
  - ARMED captures a debounced falling edge (1->0) instead of a rising edge. This matches COSMAC VIP Fx0A semantics.
  - A key already held at arming is eligible: its release acks.
  - Tie rule is unchanged: lowest hex value wins.
- Undefined: press-edge capture as specified in Behaviour.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, scan period 16 cycles):
- Reset then free-run -> col_out sequence 1110,1101,1011,0111, each held 4 cycles, repeating; keys=0.
- Hold row1 low during column 2 slots (key 6) -> keys=16'h0040 after the 2nd column-2 sample. key_query=6 gives key_pressed=1; key_query=5 gives key_pressed=0. Release -> keys=0 after 2 samples.
- Single-sample glitch on key A (row3, column 0) -> keys stays 0; its debounce counter returns to 0 on the next agreeing sample.
- wait_req=1, then press key 0 (row3, column 1) -> exactly one wait_ack pulse with wait_key=0. Holding wait_req gives no further ack; drop and re-raise wait_req, then press again -> a second ack.
- Key 5 held before wait_req rises, then wait_req=1, then press keys 1 and 4 (both column 0) in the same sample -> wait_key=1. The held key 5 gives no ack.
- Assert rst_n=0 while ARMED with a debounce in progress -> wait_ack stays 0, keys=0, col_out=1110 immediately. KEYPAD_RELEASE_WAIT_EN build: hold key F, arm, release -> ack with wait_key=F.
